// File: rtl/joypad_port_if.sv
// CPU-side bus bundle for the NES controller port responder.
// The CPU/bus decoder is the master; the joypad port is the slave.
interface joypad_port_if;
    logic        cpu_ce;    // one-Clk pulse at the end of each CPU bus cycle
    logic [15:0] cpu_addr;  // CPU address
    logic        cpu_rw_n;  // 1 = read, 0 = write
    logic [7:0]  cpu_din;   // CPU write data
    logic [7:0]  cpu_dout;  // read data returned by the port
    logic        cpu_doe;   // port is driving the read bus

    modport master (
        output cpu_ce, cpu_addr, cpu_rw_n, cpu_din,
        input  cpu_dout, cpu_doe
    );

    modport slave (
        input  cpu_ce, cpu_addr, cpu_rw_n, cpu_din,
        output cpu_dout, cpu_doe
    );
endinterface

// File: rtl/joypad_port.sv
// NES controller port 1 responder at $4016/$4017.
// Maps USB HID keycodes onto the 8-bit NES button vector and implements
// the strobe / latch / serial-shift protocol the 6502 uses to poll the pad.
module joypad_port #(
    parameter logic [7:0] KEY_A      = 8'h1B,
    parameter logic [7:0] KEY_B      = 8'h1D,
    parameter logic [7:0] KEY_SELECT = 8'h2C,
    parameter logic [7:0] KEY_START  = 8'h28,
    parameter logic [7:0] KEY_UP     = 8'h1A,
    parameter logic [7:0] KEY_DOWN   = 8'h16,
    parameter logic [7:0] KEY_LEFT   = 8'h04,
    parameter logic [7:0] KEY_RIGHT  = 8'h07
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [31:0]         keycodes,
    output logic [7:0]          buttons_dbg,
    joypad_port_if.slave        bus
);

    // Button order bit0..bit7: A, B, Select, Start, Up, Down, Left, Right.
    localparam logic [7:0] KEY_TAB [8] = '{
        KEY_A, KEY_B, KEY_SELECT, KEY_START,
        KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT
    };

    logic [7:0] btn_q, btn_d;
    logic       strobe_q, strobe_d;
    logic [7:0] shreg_q, shreg_d;

    logic sel_4016, sel_4017;
    logic wr_4016, rd_4016_ce;
    logic serial_bit;

    // A button is pressed when any slot carries its code; an empty slot
    // (8'h00) can never match because the comparison also requires the
    // table entry to be non-zero.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_btn
            assign btn_d[gi] = (KEY_TAB[gi] != 8'h00) &&
                               ((keycodes[7:0]   == KEY_TAB[gi]) ||
                                (keycodes[15:8]  == KEY_TAB[gi]) ||
                                (keycodes[23:16] == KEY_TAB[gi]) ||
                                (keycodes[31:24] == KEY_TAB[gi]));
        end
    endgenerate

    assign buttons_dbg = btn_q;

    assign sel_4016   = (bus.cpu_addr == 16'h4016);
    assign sel_4017   = (bus.cpu_addr == 16'h4017);
    assign wr_4016    = bus.cpu_ce && !bus.cpu_rw_n && sel_4016;
    assign rd_4016_ce = bus.cpu_ce &&  bus.cpu_rw_n && sel_4016;

    // While strobe is high the pad reports the live A button; otherwise
    // the head of the shift register.
    assign serial_bit = strobe_q ? btn_q[0] : shreg_q[0];

    // Read decode: purely combinational so data is valid within the same CPU cycle.
    always_comb begin
        bus.cpu_doe  = 1'b0;
        bus.cpu_dout = 8'h00;
        if (bus.cpu_rw_n && sel_4016) begin
            bus.cpu_doe  = 1'b1;
            bus.cpu_dout = {3'b010, 4'b0000, serial_bit};
        end else if (bus.cpu_rw_n && sel_4017) begin
            bus.cpu_doe  = 1'b1;
            bus.cpu_dout = 8'h40;   // pad 2 absent
        end
    end

    // Next-state for strobe and shift register.
    // Reload happens on every Clk while strobe is high, which also covers the
    // write that clears strobe: that edge latches the pre-edge btn_q. Shifting
    // on a read only happens with strobe low, filling with 1s from the top.
    always_comb begin
        strobe_d = strobe_q;
        shreg_d  = shreg_q;
        if (strobe_q) begin
            shreg_d = btn_q;
        end
        if (wr_4016) begin
            strobe_d = bus.cpu_din[0];
        end else if (rd_4016_ce && !strobe_q) begin
            shreg_d = {1'b1, shreg_q[7:1]};
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            btn_q    <= 8'h00;
            strobe_q <= 1'b0;
            shreg_q  <= 8'h00;
        end else begin
            btn_q    <= btn_d;
            strobe_q <= strobe_d;
            shreg_q  <= shreg_d;
        end
    end

endmodule

// File: doc/joypad_port.md
Name: joypad_port

Overview:
- CPU-side responder for NES controller port 1 at $4016/$4017.
- Turns the USB keyboard keycodes exported by the SOC into the 8-bit NES button vector.
- Implements the strobe/latch/serial-shift protocol the 6502 uses to poll the pad.
- Sits inside the NES bus decode beside the CPU, on the same bus as PRG RAM/ROM and the PPU registers.

Parameters:
- KEY_A, 8'h1B, HID code for button A (X key)
- KEY_B, 8'h1D, HID code for button B (Z key)
- KEY_SELECT, 8'h2C, HID code for Select (Space)
- KEY_START, 8'h28, HID code for Start (Enter)
- KEY_UP, 8'h1A, HID code for Up (W)
- KEY_DOWN, 8'h16, HID code for Down (S)
- KEY_LEFT, 8'h04, HID code for Left (A)
- KEY_RIGHT, 8'h07, HID code for Right (D)

Ports:
- Clk  in  1  system clock (MCLK)
- Reset_n  in  1  asynchronous active-low reset
- keycodes  in  32  four HID key slots, slot0 = [7:0]; 8'h00 = empty; unused slots tied 0
- cpu_ce  in  1  one-Clk pulse marking the end of each CPU bus cycle
- cpu_addr  in  16  CPU address
- cpu_rw_n  in  1  1 = read, 0 = write
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  read data
- cpu_doe  out  1  high when this block drives the CPU read bus
- buttons_dbg  out  8  current live button vector, for LEDR

Behaviour:
- Button order, bit0 to bit7: A, B, Select, Start, Up, Down, Left, Right.
- btn_q register:
  - Updated every Clk; bit i = 1 if any of the 4 keycode slots equals that button's parameter.
  - Slot value 8'h00 never matches.
  - Duplicate codes in several slots are harmless.
  - One Clk latency from keycodes. buttons_dbg = btn_q.
- State is strobe (1b) and shreg (8b). State changes only on Clk edges with cpu_ce = 1, except the btn_q reload below.
- Write decode: cpu_ce & ~cpu_rw_n & addr == 16'h4016 -> strobe <= cpu_din[0]. Bits 7:1 are ignored.
- Reload: every Clk while strobe = 1, shreg <= btn_q.
  - On the write that clears strobe (1 -> 0), shreg <= btn_q in that same cycle. The latched value is btn_q at that edge.
  - Writing 0 while strobe is already 0 leaves shreg unchanged.
- Read $4016 (cpu_rw_n = 1, addr == 16'h4016):
  - cpu_doe = 1 combinationally; cpu_dout = {3'b010, 4'b0000, bit}.
  - bit = btn_q[0] if strobe = 1, else shreg[0].
- Read side effect: on the cpu_ce edge of a $4016 read with strobe = 0, shreg <= {1'b1, shreg[7:1]}.
  - After 8 reads, every further read returns bit = 1.
  - With strobe = 1 there is no shift.
- Read $4017: cpu_doe = 1, cpu_dout = 8'h40 (pad 2 absent). shreg is unaffected.
- All other addresses, and all writes: cpu_doe = 0, cpu_dout = 8'h00.
- Simultaneous events:
  - A $4016 write and a keycode change in the same cycle: the latch uses the old btn_q.
  - Keycodes changing during shifting never alter shreg.
- Reset values (async, immediate on Reset_n low): strobe 0, shreg 8'h00, btn_q 8'h00. cpu_dout and cpu_doe follow decode.
- Reset mid-shift clears shreg. Reads after reset, before any strobe, return bit = 0 until the fill 1s arrive.
- cpu_dout/cpu_doe are purely combinational from address/rw_n/state. No extra latency within the CPU cycle.

Test Plan:
- Reset -> buttons_dbg = 0, read $4016 with strobe 0 -> cpu_dout = 8'h40, cpu_doe = 1; a read of $4000 -> cpu_doe = 0.
- keycodes = 32'h0000_281B (X + Enter); write $4016 = 1, then 0; 8 reads -> bits 1,0,0,1,0,0,0,0 (cpu_dout 41,40,40,41,40,40,40,40); reads 9-10 -> 8'h41.
- Strobe held 1, keycodes = 32'h1B; 3 reads -> each 8'h41 and no shift; change keycodes to 32'h0 -> next read 8'h40 after 1 Clk.
- Latch A + Right (32'h071B), release all keys mid-sequence after 2 reads -> reads 3-8 still 0,0,0,0,0,1.
- Reads of $4017 interleaved between $4016 reads -> each $4017 returns 8'h40; the $4016 sequence is undisturbed.
- Assert Reset_n low after 3 reads -> shreg = 0, strobe = 0 asynchronously; following reads -> 40,40,... then 41 from read 9 on (fill 1s).
